flash_boot_copier: RTL and testbench

FLASH_BOOT_COPIER -- requirements
Module: flash_boot_copier

---
 rtl/flash_boot_copier.sv | 212 +++++++++++++++++++++
 tb/tb_flash_boot_copier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_boot_copier.sv
// Boot copier: streams a length-prefixed image out of SPI flash (read command
// 03h, mode 0) and writes it word by word into an asynchronous SRAM.
module flash_boot_copier #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h080000,
  parameter int unsigned WE_CYCLES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        SPIFlash_bootCEJ,
  output logic        SPIFlash_bootSCK,
  output logic        SPIFlash_bootSI,
  input  logic        SPIFlash_bootSO,
  output logic        sram_csn,
  output logic        sram_wen,
  output logic        sram_oen,
  output logic [1:0]  sram_be,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dout,
  output logic        sram_doe,
  output logic        platform_rst_n,
  output logic        boot_done,
  output logic        boot_err
);

  typedef enum logic [2:0] {IDLE, CMD, HDR, CHECK, DATA, WRITE, DONE, ERR} stateT;

  localparam logic [31:0] CmdWord = {8'h03, FLASH_BASE};
  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
  localparam logic [4:0]  WenRise = 5'(WE_CYCLES);
  localparam logic [4:0]  WrLast  = 5'(WE_CYCLES + 1);

  stateT       state, stateD;
  logic        cej, cejD, sck, sckD, si, siD;
  logic        csn, csnD, wen, wenD, doe, doeD;
  logic [1:0]  be, beD;
  logic [17:0] addr, addrD, addrNext;
  logic [15:0] dout, doutD, shiftIn, shiftInD, nWords, nWordsD;
  logic [31:0] shiftOut, shiftOutD;
  logic [7:0]  divCnt, divCntD;
  logic [5:0]  bitCnt, bitCntD;
  logic [4:0]  wCnt, wCntD;
  logic        platRstN, platRstND, bootDone, bootDoneD, bootErr, bootErrD;
  logic        phaseEnd, lastBit;

  assign phaseEnd = (divCnt == DivLast);
  assign lastBit  = (state == CMD) ? (bitCnt == 6'd31) : (bitCnt == 6'd15);
  assign addrNext = addr + 18'd1;

  // Every output comes straight from a flop; reset also aborts any SRAM write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cej      <= 1'b1;
      sck      <= 1'b0;
      si       <= 1'b0;
      csn      <= 1'b1;
      wen      <= 1'b1;
      doe      <= 1'b0;
      be       <= 2'b11;
      addr     <= '0;
      dout     <= '0;
      shiftIn  <= '0;
      nWords   <= '0;
      shiftOut <= '0;
      divCnt   <= '0;
      bitCnt   <= '0;
      wCnt     <= '0;
      platRstN <= 1'b0;
      bootDone <= 1'b0;
      bootErr  <= 1'b0;
    end else begin
      state    <= stateD;
      cej      <= cejD;
      sck      <= sckD;
      si       <= siD;
      csn      <= csnD;
      wen      <= wenD;
      doe      <= doeD;
      be       <= beD;
      addr     <= addrD;
      dout     <= doutD;
      shiftIn  <= shiftInD;
      nWords   <= nWordsD;
      shiftOut <= shiftOutD;
      divCnt   <= divCntD;
      bitCnt   <= bitCntD;
      wCnt     <= wCntD;
      platRstN <= platRstND;
      bootDone <= bootDoneD;
      bootErr  <= bootErrD;
    end
  end

  always_comb begin
    stateD    = state;
    cejD      = cej;
    sckD      = sck;
    siD       = si;
    csnD      = csn;
    wenD      = wen;
    doeD      = doe;
    beD       = be;
    addrD     = addr;
    doutD     = dout;
    shiftInD  = shiftIn;
    nWordsD   = nWords;
    shiftOutD = shiftOut;
    divCntD   = divCnt;
    bitCntD   = bitCnt;
    wCntD     = wCnt;
    platRstND = platRstN;
    bootDoneD = bootDone;
    bootErrD  = bootErr;
    case (state)
      IDLE: begin
        cejD      = 1'b0;
        siD       = CmdWord[31];
        shiftOutD = CmdWord;
        divCntD   = '0;
        bitCntD   = '0;
        stateD    = CMD;
      end
      // SO is captured on the rising SCK edge; SI advances on the falling one.
      CMD, HDR, DATA: begin
        if (!phaseEnd) begin
          divCntD = divCnt + 8'd1;
        end else begin
          divCntD = '0;
          if (!sck) begin
            sckD     = 1'b1;
            shiftInD = {shiftIn[14:0], SPIFlash_bootSO};
          end else begin
            sckD      = 1'b0;
            bitCntD   = bitCnt + 6'd1;
            shiftOutD = shiftOut << 1;
            siD       = shiftOut[30];
            if (lastBit) begin
              bitCntD = '0;
              siD     = 1'b0;
              case (state)
                CMD: stateD = HDR;
                HDR: begin
                  nWordsD = shiftIn;
                  stateD  = CHECK;
                end
                default: begin
                  stateD = WRITE;
                  csnD   = 1'b0;
                  beD    = 2'b00;
                  doeD   = 1'b1;
                  doutD  = shiftIn;
                  wCntD  = '0;
                end
              endcase
            end
          end
        end
      end
      CHECK: begin
        if (nWords == 16'h0000 || nWords == 16'hFFFF) begin
          stateD   = ERR;
          cejD     = 1'b1;
          sckD     = 1'b0;
          bootErrD = 1'b1;
        end else begin
          stateD = DATA;
        end
      end
      // One setup cycle, WE_CYCLES of wen low, then one hold cycle.
      WRITE: begin
        wCntD = wCnt + 5'd1;
        wenD  = (wCnt < WenRise) ? 1'b0 : 1'b1;
        if (wCnt == WrLast) begin
          wenD    = 1'b1;
          csnD    = 1'b1;
          beD     = 2'b11;
          doeD    = 1'b0;
          addrD   = addrNext;
          divCntD = '0;
          bitCntD = '0;
          if (addrNext == {2'b00, nWords}) begin
            stateD    = DONE;
            cejD      = 1'b1;
            sckD      = 1'b0;
            bootDoneD = 1'b1;
            platRstND = 1'b1;
          end else begin
            stateD = DATA;
          end
        end
      end
      DONE: stateD = DONE;
      ERR:  stateD = ERR;
    endcase
  end

  assign SPIFlash_bootCEJ = cej;
  assign SPIFlash_bootSCK = sck;
  assign SPIFlash_bootSI  = si;
  assign sram_csn         = csn;
  assign sram_wen         = wen;
  assign sram_oen         = 1'b1;
  assign sram_be          = be;
  assign sram_addr        = addr;
  assign sram_dout        = dout;
  assign sram_doe         = doe;
  assign platform_rst_n   = platRstN;
  assign boot_done        = bootDone;
  assign boot_err         = bootErr;

endmodule

// File: tb/tb_flash_boot_copier.sv
// Bench for flash_boot_copier: one instance at default timing and one at the
// fastest legal timing, each with a behavioural SPI flash and SRAM.
module tb_flash_boot_copier;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [7:0] flashMem [2][16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int unsigned Div = (g == 0) ? 2 : 1;
    localparam int unsigned We  = (g == 0) ? 2 : 1;

    logic        cej, sck, si, csn, wen, oen, doe, prstN, done, err;
    logic        so = 1'b0;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] dout;
    logic [31:0] cmdCap = '0;
    logic [15:0] sram [16];
    logic        sckPrev = 1'b0, wenPrev = 1'b1, donePrev = 1'b0;
    int riseCnt = 0, writeCount = 0, violations = 0, bitIdx = 0;
    int hiMin = 1000, hiMax = 0, perMin = 1000, perMax = 0, per = 0, hi = 0;
    int csnRun = 0, wenRun = 0, wenFirst = 0;
    int lastCsnRun = 0, lastWenRun = 0, lastWenFirst = 0;
    longint lastRise = 0, lastWenRiseT = 0, doneRiseT = 0;

    flash_boot_copier #(.CLK_DIV(Div), .FLASH_BASE(24'h080000), .WE_CYCLES(We)) dut (
      .clk_i(clk), .rst_i(rst[g]),
      .SPIFlash_bootCEJ(cej), .SPIFlash_bootSCK(sck), .SPIFlash_bootSI(si),
      .SPIFlash_bootSO(so),
      .sram_csn(csn), .sram_wen(wen), .sram_oen(oen), .sram_be(be),
      .sram_addr(addr), .sram_dout(dout), .sram_doe(doe),
      .platform_rst_n(prstN), .boot_done(done), .boot_err(err)
    );

    // Flash, SRAM and protocol monitors, all sampled mid-cycle.
    always @(negedge clk) begin
      if (cej && sck) violations++;
      if (csn && !wen) violations++;
      if (done && err) violations++;
      if (rst[g]) begin
        cmdCap = '0;
        writeCount = 0;
        hiMin = 1000; hiMax = 0; perMin = 1000; perMax = 0;
        for (int i = 0; i < 16; i++) sram[i] = '0;
      end
      if (cej) begin
        riseCnt = 0;
      end else if (sck && !sckPrev) begin
        if (riseCnt < 32) cmdCap = {cmdCap[30:0], si};
        if (riseCnt >= 1 && riseCnt < 32) begin
          per = int'(($time - lastRise) / 10);
          if (per < perMin) perMin = per;
          if (per > perMax) perMax = per;
        end
        lastRise = $time;
        riseCnt++;
      end else if (!sck && sckPrev) begin
        hi = int'(($time - lastRise) / 10);
        if (hi < hiMin) hiMin = hi;
        if (hi > hiMax) hiMax = hi;
        bitIdx = riseCnt - 32;
        if (bitIdx >= 0 && bitIdx < 128) so = flashMem[g][bitIdx / 8][7 - (bitIdx % 8)];
        else so = 1'b1;
      end
      if (!csn) begin
        if (!wen && wenRun == 0) wenFirst = csnRun;
        if (!wen) wenRun++;
        csnRun++;
      end else if (csnRun > 0) begin
        lastCsnRun = csnRun; lastWenRun = wenRun; lastWenFirst = wenFirst;
        csnRun = 0; wenRun = 0;
      end
      if (!wenPrev && wen && !csn) begin
        if (addr < 18'd16) sram[addr[3:0]] = dout;
        writeCount++;
        lastWenRiseT = $time;
      end
      if (done && !donePrev) doneRiseT = $time;
      sckPrev = sck; wenPrev = wen; donePrev = done;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [15:0] n,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
    rst[inst] = 1'b1;
    flashMem[inst][0] = n[15:8];  flashMem[inst][1] = n[7:0];
    flashMem[inst][2] = w0[15:8]; flashMem[inst][3] = w0[7:0];
    flashMem[inst][4] = w1[15:8]; flashMem[inst][5] = w1[7:0];
    flashMem[inst][6] = w2[15:8]; flashMem[inst][7] = w2[7:0];
    flashMem[inst][8] = w3[15:8]; flashMem[inst][9] = w3[7:0];
    for (int i = 10; i < 16; i++) flashMem[inst][i] = 8'hFF;
    repeat (3) @(negedge clk);
    rst[inst] = 1'b0;
  endtask

  task automatic waitEnd0();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (h[0].done || h[0].err) break;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic checkErrResponse(input string tag);
    checkOutput({tag, "_err"}, h[0].err, 1);
    checkOutput({tag, "_done"}, h[0].done, 0);
    checkOutput({tag, "_writes"}, h[0].writeCount, 0);
    checkOutput({tag, "_prstN"}, h[0].prstN, 0);
    checkOutput({tag, "_cej"}, h[0].cej, 1);
    checkOutput({tag, "_sck"}, h[0].sck, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetCtrl", {h[0].cej, h[0].sck, h[0].si, h[0].csn, h[0].wen, h[0].oen,
                              h[0].be, h[0].doe, h[0].prstN, h[0].done, h[0].err}, 12'h9F0);
    checkOutput("resetAddr", h[0].addr, 0);
    checkOutput("resetDout", h[0].dout, 0);

    // Normal three-word image
    applyStimulus(0, 16'h0003, 16'h1234, 16'hABCD, 16'h0F0F, 16'h0000);
    checkOutput("cejBeforeIdle", h[0].cej, 1);
    @(negedge clk);
    checkOutput("cejAfterIdle", h[0].cej, 0);
    checkOutput("sckAfterIdle", h[0].sck, 0);
    waitEnd0();
    checkOutput("cmdBits", h[0].cmdCap, 32'h03080000);
    checkOutput("sram0", h[0].sram[0], 16'h1234);
    checkOutput("sram1", h[0].sram[1], 16'hABCD);
    checkOutput("sram2", h[0].sram[2], 16'h0F0F);
    checkOutput("writes3", h[0].writeCount, 3);
    checkOutput("doneAfterWen", int'(h[0].doneRiseT - h[0].lastWenRiseT), 10);
    checkOutput("doneFlags", {h[0].done, h[0].err, h[0].prstN, h[0].cej, h[0].csn, h[0].doe}, 6'b101110);
    checkOutput("sckHighMin", h[0].hiMin, 2);
    checkOutput("sckHighMax", h[0].hiMax, 2);
    checkOutput("sckPeriodMin", h[0].perMin, 4);
    checkOutput("sckPeriodMax", h[0].perMax, 4);
    checkOutput("csnLowLen", h[0].lastCsnRun, 4);
    checkOutput("wenLowLen", h[0].lastWenRun, 2);
    checkOutput("wenSetup", h[0].lastWenFirst, 1);

    // Invalid headers
    applyStimulus(0, 16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    checkOutput("prstLowAfterReset", h[0].prstN, 0);
    checkOutput("doneClearedByReset", h[0].done, 0);
    waitEnd0();
    checkErrResponse("hdrFFFF");
    applyStimulus(0, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    waitEnd0();
    checkErrResponse("hdr0000");

    // Reset during the second write of a four-word image
    applyStimulus(0, 16'h0004, 16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (h[0].writeCount == 1 && !h[0].wen) break;
    end
    checkOutput("preResetWrites", h[0].writeCount, 1);
    checkOutput("write2Addr", h[0].addr, 1);
    checkOutput("write2Dout", h[0].dout, 16'h8000);
    checkOutput("write2BeDoe", {h[0].be, h[0].doe}, 3'b001);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortWen", h[0].wen, 1);
    checkOutput("abortCsn", h[0].csn, 1);
    checkOutput("abortCej", h[0].cej, 1);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    waitEnd0();
    checkOutput("rerunWrites", h[0].writeCount, 4);
    checkOutput("rerun0", h[0].sram[0], 16'h0001);
    checkOutput("rerun1", h[0].sram[1], 16'h8000);
    checkOutput("rerun2", h[0].sram[2], 16'hA5A5);
    checkOutput("rerun3", h[0].sram[3], 16'h5A5A);
    checkOutput("rerunDone", {h[0].done, h[0].prstN}, 2'b11);

    // Fastest timing, single word
    applyStimulus(1, 16'h0001, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (h[1].done || h[1].err) break;
    end
    repeat (3) @(negedge clk);
    checkOutput("fastCmd", h[1].cmdCap, 32'h03080000);
    checkOutput("fastSram0", h[1].sram[0], 16'hBEEF);
    checkOutput("fastWrites", h[1].writeCount, 1);
    checkOutput("fastHighMin", h[1].hiMin, 1);
    checkOutput("fastHighMax", h[1].hiMax, 1);
    checkOutput("fastPeriodMin", h[1].perMin, 2);
    checkOutput("fastPeriodMax", h[1].perMax, 2);
    checkOutput("fastCsnLen", h[1].lastCsnRun, 3);
    checkOutput("fastWenLen", h[1].lastWenRun, 1);
    checkOutput("fastWenSetup", h[1].lastWenFirst, 1);
    checkOutput("fastDone", {h[1].done, h[1].err, h[1].prstN}, 3'b101);

    checkOutput("protocolA", h[0].violations, 0);
    checkOutput("protocolB", h[1].violations, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
